// File: rtl/remask_pipe.sv
// Share-refresh pipeline stage for threshold-implementation datapaths.
// Fresh randomness is XORed into NSHARES shares so that the XOR of all shares
// is unchanged, and the result is held in a register. That register is the
// glitch barrier between S-box stages. Share data and randomness each have
// their own valid/ready pair, and are always consumed together.
module remask_pipe #(
   parameter int  NSHARES = 4,
   parameter int  WIDTH   = 8,
   parameter int  MODE    = 0,
   parameter int  CNT_W   = 16,
   localparam int RAND_W  = (MODE != 0) ? (NSHARES-1)*WIDTH : NSHARES*WIDTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NSHARES*WIDTH-1:0]   in_shares_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [RAND_W-1:0]          rand_i,
   input  logic                       rand_valid_i,
   output logic                       rand_ready_o,
   output logic [NSHARES*WIDTH-1:0]   out_shares_o,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [CNT_W-1:0]           op_cnt_o,
   output logic [CNT_W-1:0]           starve_cnt_o
);

   if (NSHARES < 2 || (MODE != 0 && MODE != 1)) begin : g_param_check
      $error("remask_pipe: NSHARES must be >= 2 and MODE must be 0 or 1");
   end

   logic                      can_load;
   logic                      fire;
   logic                      starve;
   logic [NSHARES*WIDTH-1:0]  rand_ext;
   logic [NSHARES*WIDTH-1:0]  refreshed;

   assign can_load     = !out_valid_o || out_ready_i;
   assign fire         = in_valid_i && rand_valid_i && can_load;
   assign starve       = in_valid_i && !rand_valid_i && can_load;
   assign in_ready_o   = rand_valid_i && can_load;
   assign rand_ready_o = in_valid_i && can_load;

   // Chain mode pads the missing top random word with zero so both modes
   // share one refresh equation: out_j = in_j ^ r_j ^ r_(j-1).
   if (MODE == 0) begin : g_ring_rand
      assign rand_ext = rand_i;
   end else begin : g_chain_rand
      assign rand_ext = {{WIDTH{1'b0}}, rand_i};
   end

   // Refresh XOR network; feeds only the output register.
   // In ring mode r_(-1) wraps to r_(N-1); in chain mode share 0 has no predecessor.
   always_comb begin
      refreshed = in_shares_i;
      for (int j = 0; j < NSHARES; j++) begin
         refreshed[j*WIDTH +: WIDTH] = in_shares_i[j*WIDTH +: WIDTH]
                                     ^ rand_ext[j*WIDTH +: WIDTH];
         if (MODE == 0 || j > 0) begin
            refreshed[j*WIDTH +: WIDTH] = refreshed[j*WIDTH +: WIDTH]
                                        ^ rand_ext[((j + NSHARES - 1) % NSHARES)*WIDTH +: WIDTH];
         end
      end
   end

   // Output register: load on fire, clear valid on drain, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_shares_o <= '0;
         out_valid_o  <= 1'b0;
      end else if (fire) begin
         out_shares_o <= refreshed;
         out_valid_o  <= 1'b1;
      end else if (out_ready_i) begin
         out_valid_o  <= 1'b0;
      end
   end

   // Saturating activity and starvation counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_cnt_o     <= '0;
         starve_cnt_o <= '0;
      end else begin
         if (fire && op_cnt_o != {CNT_W{1'b1}}) begin
            op_cnt_o <= op_cnt_o + 1'b1;
         end
         if (starve && starve_cnt_o != {CNT_W{1'b1}}) begin
            starve_cnt_o <= starve_cnt_o + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_remask_pipe.sv
// Directed bench for remask_pipe: ring, chain and small-counter instances.
module tb_remask_pipe;

   logic        clk = 1'b0;
   logic        rst_n;

   // ring instance (also drives the 4-bit counter instance)
   logic [31:0] r_in;
   logic        r_iv;
   logic        r_irdy;
   logic [31:0] r_rand;
   logic        r_rv;
   logic        r_rrdy;
   logic [31:0] r_out;
   logic        r_ov;
   logic        r_ordy;
   logic [15:0] r_op;
   logic [15:0] r_starve;

   // chain instance
   logic [31:0] c_in;
   logic        c_iv;
   logic        c_irdy;
   logic [23:0] c_rand;
   logic        c_rv;
   logic        c_rrdy;
   logic [31:0] c_out;
   logic        c_ov;
   logic        c_ordy;
   logic [15:0] c_op;
   logic [15:0] c_starve;

   // saturation instance outputs
   logic        s_irdy;
   logic        s_rrdy;
   logic [31:0] s_out;
   logic        s_ov;
   logic [3:0]  s_op;
   logic [3:0]  s_starve;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   remask_pipe #(.NSHARES(4), .WIDTH(8), .MODE(0), .CNT_W(16)) u_ring (
      .clk(clk), .rst_n(rst_n),
      .in_shares_i(r_in), .in_valid_i(r_iv), .in_ready_o(r_irdy),
      .rand_i(r_rand), .rand_valid_i(r_rv), .rand_ready_o(r_rrdy),
      .out_shares_o(r_out), .out_valid_o(r_ov), .out_ready_i(r_ordy),
      .op_cnt_o(r_op), .starve_cnt_o(r_starve)
   );

   remask_pipe #(.NSHARES(4), .WIDTH(8), .MODE(1), .CNT_W(16)) u_chain (
      .clk(clk), .rst_n(rst_n),
      .in_shares_i(c_in), .in_valid_i(c_iv), .in_ready_o(c_irdy),
      .rand_i(c_rand), .rand_valid_i(c_rv), .rand_ready_o(c_rrdy),
      .out_shares_o(c_out), .out_valid_o(c_ov), .out_ready_i(c_ordy),
      .op_cnt_o(c_op), .starve_cnt_o(c_starve)
   );

   remask_pipe #(.NSHARES(4), .WIDTH(8), .MODE(0), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n),
      .in_shares_i(r_in), .in_valid_i(r_iv), .in_ready_o(s_irdy),
      .rand_i(r_rand), .rand_valid_i(r_rv), .rand_ready_o(s_rrdy),
      .out_shares_o(s_out), .out_valid_o(s_ov), .out_ready_i(r_ordy),
      .op_cnt_o(s_op), .starve_cnt_o(s_starve)
   );

   function automatic logic [7:0] fold(input logic [31:0] v);
      logic [7:0] acc;
      acc = 8'h00;
      for (int k = 0; k < 4; k++) acc = acc ^ v[k*8 +: 8];
      return acc;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n  = 1'b0;
      r_in   = '0; r_iv = 1'b0; r_rand = '0; r_rv = 1'b0; r_ordy = 1'b1;
      c_in   = '0; c_iv = 1'b0; c_rand = '0; c_rv = 1'b0; c_ordy = 1'b1;

      // reset state
      cyc(); cyc();
      chk("rst_out",    r_out, 64'h0);
      chk("rst_valid",  r_ov, 64'h0);
      chk("rst_op",     r_op, 64'h0);
      chk("rst_starve", c_starve, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();

      // T1 ring / T2 chain
      r_in = 32'h88442211; r_rand = 32'h08040201; r_iv = 1'b1; r_rv = 1'b1;
      c_in = 32'h88442211; c_rand = 24'h040201;   c_iv = 1'b1; c_rv = 1'b1;
      #1;
      chk("t1_in_ready",   r_irdy, 64'h1);
      chk("t1_rand_ready", r_rrdy, 64'h1);
      chk("t1_no_early_valid", r_ov, 64'h0);
      cyc();
      chk("t1_out",    r_out, 64'h84422118);
      chk("t1_valid",  r_ov, 64'h1);
      chk("t1_op",     r_op, 64'h1);
      chk("t2_out",    c_out, 64'h8c422110);
      chk("t2_xor",    fold(c_out), 64'hff);
      chk("t2_op",     c_op, 64'h1);
      r_iv = 1'b0; r_rv = 1'b0; c_iv = 1'b0; c_rv = 1'b0;
      cyc();
      chk("t1_drain_valid", r_ov, 64'h0);
      chk("t1_drain_op",    r_op, 64'h1);

      // T3 backpressure with a pending word
      r_ordy = 1'b0;
      r_in = 32'h01020304; r_rand = 32'h0; r_iv = 1'b1; r_rv = 1'b1;
      cyc();
      chk("t3_load_a", r_out, 64'h01020304);
      chk("t3_op_a",   r_op, 64'h2);
      r_in = 32'h0a0b0c0d; r_rand = 32'h00000080;
      #1;
      chk("t3_in_ready_bp",   r_irdy, 64'h0);
      chk("t3_rand_ready_bp", r_rrdy, 64'h0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t3_hold_out",   r_out, 64'h01020304);
         chk("t3_hold_valid", r_ov, 64'h1);
         chk("t3_hold_op",    r_op, 64'h2);
      end
      r_ordy = 1'b1;
      #1;
      chk("t3_in_ready_rel", r_irdy, 64'h1);
      cyc();
      chk("t3_word_b",  r_out, 64'h0a0b8c8d);
      chk("t3_op_b",    r_op, 64'h3);
      r_in = 32'h55667788; r_rand = 32'h0;
      cyc();
      chk("t3_word_c",  r_out, 64'h55667788);
      chk("t3_valid_c", r_ov, 64'h1);
      chk("t3_op_c",    r_op, 64'h4);
      r_iv = 1'b0; r_rv = 1'b0;
      cyc();
      chk("t3_drain", r_ov, 64'h0);

      // T4 randomness starvation
      r_in = 32'hdeadbeef; r_rand = 32'h0; r_iv = 1'b1; r_rv = 1'b0;
      #1;
      chk("t4_rand_ready", r_rrdy, 64'h1);
      chk("t4_in_ready",   r_irdy, 64'h0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("t4_no_valid", r_ov, 64'h0);
         chk("t4_no_op",    r_op, 64'h4);
      end
      chk("t4_starve", r_starve, 64'h5);
      r_rv = 1'b1;
      #1;
      chk("t4_in_ready_now", r_irdy, 64'h1);
      cyc();
      chk("t4_out",    r_out, 64'hdeadbeef);
      chk("t4_op",     r_op, 64'h5);
      chk("t4_starve_hold", r_starve, 64'h5);
      r_iv = 1'b0; r_rv = 1'b0;
      cyc();
      chk("t4_single_fire", r_op, 64'h5);

      // T6 counter saturation on the 4-bit instance
      chk("t6_sat_start", s_op, 64'h5);
      r_iv = 1'b1; r_rv = 1'b1;
      for (int i = 0; i < 20; i++) begin
         r_in = 32'(i * 32'h01010101);
         cyc();
         if (i == 8)  chk("t6_sat_14", s_op, 64'he);
         if (i == 9)  chk("t6_sat_15", s_op, 64'hf);
      end
      chk("t6_sat_hold", s_op, 64'hf);
      chk("t6_wide_op",  r_op, 64'd25);

      // random streams, XOR-sum preserved on every word in both modes
      c_iv = 1'b1; c_rv = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         r_in = $urandom; r_rand = $urandom;
         c_in = $urandom; c_rand = 24'($urandom);
         cyc();
         chk("rnd_ring_xor",  fold(r_out), fold(r_in));
         chk("rnd_chain_xor", fold(c_out), fold(c_in));
      end
      chk("rnd_chain_op", c_op, 64'd10001);
      chk("rnd_ring_valid", r_ov, 64'h1);

      // T5 asynchronous reset mid-stream, away from any clock edge
      r_iv = 1'b0; r_rv = 1'b0; c_iv = 1'b0; c_rv = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_out",    r_out, 64'h0);
      chk("t5_valid",  r_ov, 64'h0);
      chk("t5_op",     r_op, 64'h0);
      chk("t5_starve", r_starve, 64'h0);
      chk("t5_chain_op", c_op, 64'h0);
      chk("t5_sat_op", s_op, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      chk("t5_after_valid", r_ov, 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
